csp_merge_arbiter: RTL

- Clocked two-requester arbiter that merges two four-phase req/ack data channels onto a single four-phase output channel.
- The output channel feeds the head of the linear full-buffer pipeline, so two generators share one pipeline.
- Round-robin fairness, one transfer in flight at a time.
- Per-port grant counters for statistics.

---
 rtl/csp_merge_arbiter.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/csp_merge_arbiter.sv
// Two-port round-robin merge arbiter for four-phase req/ack channels feeding one output channel.
// One transfer is in flight at a time, and each port has a saturating grant counter.
module csp_merge_arbiter #(
    parameter int WIDTH = 8,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cnt_clr,
    input  logic             in0_req,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ack,
    input  logic             in1_req,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ack,
    output logic             out_req,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ack,
    output logic             grant_id,
    output logic             busy,
    output logic [CW-1:0]    cnt0,
    output logic [CW-1:0]    cnt1
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_REL  = 2'd2,
        S_ACK  = 2'd3
    } state_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        if (v == {CW{1'b1}}) begin
            r = v;
        end else begin
            r = v + CW'(1);
        end
        return r;
    endfunction

    state_t           state_r;
    state_t           state_nx_s;
    logic             ack0_r;
    logic             ack1_r;
    logic             out_req_r;
    logic             busy_r;
    logic             grant_r;
    logic             last_r;
    logic [WIDTH-1:0] data_r;
    logic [CW-1:0]    cnt0_r;
    logic [CW-1:0]    cnt1_r;

    logic             elig0_s;
    logic             elig1_s;
    logic             gnt_valid_s;
    logic             gnt_port_s;
    logic             gnt_req_s;
    logic             done_s;
    logic             out_req_nx_s;
    logic             ack0_nx_s;
    logic             ack1_nx_s;
    logic             busy_nx_s;

    assign elig0_s   = in0_req & ~ack0_r;
    assign elig1_s   = in1_req & ~ack1_r;
    assign gnt_req_s = grant_r ? in1_req : in0_req;
    assign done_s    = (state_r == S_ACK) & ~gnt_req_s;

    // Grant decision in IDLE; under contention the port not served last wins.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_port_s  = 1'b0;
        if ((state_r == S_IDLE) && enable) begin
            if (elig0_s && elig1_s) begin
                gnt_valid_s = 1'b1;
                gnt_port_s  = ~last_r;
            end else if (elig0_s) begin
                gnt_valid_s = 1'b1;
                gnt_port_s  = 1'b0;
            end else if (elig1_s) begin
                gnt_valid_s = 1'b1;
                gnt_port_s  = 1'b1;
            end else begin
                gnt_valid_s = 1'b0;
                gnt_port_s  = 1'b0;
            end
        end else begin
            gnt_valid_s = 1'b0;
            gnt_port_s  = 1'b0;
        end
    end

    // Next-state logic for the four-phase handshake sequence.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (gnt_valid_s) begin
                    state_nx_s = S_REQ;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (out_ack) begin
                    state_nx_s = S_REL;
                end else begin
                    state_nx_s = S_REQ;
                end
            end
            S_REL: begin
                if (!out_ack) begin
                    state_nx_s = S_ACK;
                end else begin
                    state_nx_s = S_REL;
                end
            end
            S_ACK: begin
                if (done_s) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_ACK;
                end
            end
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Output decode from the next state so every output comes straight from a flop.
    always_comb begin
        out_req_nx_s = 1'b0;
        ack0_nx_s    = 1'b0;
        ack1_nx_s    = 1'b0;
        busy_nx_s    = 1'b0;
        case (state_nx_s)
            S_IDLE: begin
                busy_nx_s = 1'b0;
            end
            S_REQ: begin
                out_req_nx_s = 1'b1;
                busy_nx_s    = 1'b1;
            end
            S_REL: begin
                busy_nx_s = 1'b1;
            end
            S_ACK: begin
                busy_nx_s = 1'b1;
                ack0_nx_s = ~grant_r;
                ack1_nx_s = grant_r;
            end
            default: begin
                busy_nx_s = 1'b0;
            end
        endcase
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            out_req_r <= 1'b0;
            ack0_r    <= 1'b0;
            ack1_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            out_req_r <= out_req_nx_s;
            ack0_r    <= ack0_nx_s;
            ack1_r    <= ack1_nx_s;
            busy_r    <= busy_nx_s;
        end
    end

    // Grant id and data capture on the grant edge; held until the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_r <= 1'b0;
            data_r  <= {WIDTH{1'b0}};
        end else if (gnt_valid_s) begin
            grant_r <= gnt_port_s;
            data_r  <= gnt_port_s ? in1_data : in0_data;
        end else begin
            grant_r <= grant_r;
            data_r  <= data_r;
        end
    end

    // Round-robin pointer; reset value 1 makes port 0 win the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= 1'b1;
        end else if (done_s) begin
            last_r <= grant_r;
        end else begin
            last_r <= last_r;
        end
    end

    // Saturating completion counters; clear overrides a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_r <= {CW{1'b0}};
            cnt1_r <= {CW{1'b0}};
        end else if (cnt_clr) begin
            cnt0_r <= {CW{1'b0}};
            cnt1_r <= {CW{1'b0}};
        end else if (done_s) begin
            if (grant_r) begin
                cnt1_r <= sat_inc(cnt1_r);
            end else begin
                cnt0_r <= sat_inc(cnt0_r);
            end
        end else begin
            cnt0_r <= cnt0_r;
            cnt1_r <= cnt1_r;
        end
    end

    assign out_req  = out_req_r;
    assign in0_ack  = ack0_r;
    assign in1_ack  = ack1_r;
    assign busy     = busy_r;
    assign grant_id = grant_r;
    assign out_data = data_r;
    assign cnt0     = cnt0_r;
    assign cnt1     = cnt1_r;

endmodule
